// File: rtl/counter_sched_pkg.sv
// -----------------------------------------------------------------------------
// counter_sched_pkg
//
// Shared definitions for the round-robin counter scheduler:
//   - state_e     : scheduler FSM encoding (IDLE, RUN, DONE)
//   - DEF_NREQ    : default number of requesters
//   - DEF_WIDTH   : default counter / limit width
//   - MAX_NREQ    : largest supported requester count
//   - MAX_WIDTH   : largest supported counter width
//   - LIM_BUS_W   : width of the widest packed limit bus
//   - lim_sel()   : pulls slice i out of a packed limit bus
//
// No ports; this is a package.
// -----------------------------------------------------------------------------
package counter_sched_pkg;

   localparam int DEF_NREQ  = 4;
   localparam int DEF_WIDTH = 8;

   // Upper bounds for the packed-limit helper.
   // Instances must keep NREQ <= MAX_NREQ and WIDTH <= MAX_WIDTH.
   localparam int MAX_NREQ  = 8;
   localparam int MAX_WIDTH = 16;
   localparam int LIM_BUS_W = MAX_NREQ * MAX_WIDTH;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Returns slice idx (bits [idx*width +: width]) of a packed limit bus.
   // The caller zero-extends its bus to LIM_BUS_W and truncates the result
   // back to its own width, so one function serves every instance width.
   function automatic logic [MAX_WIDTH-1:0] lim_sel(
      input logic [LIM_BUS_W-1:0] limit,
      input int                   idx,
      input int                   width
   );
      logic [LIM_BUS_W-1:0] shifted;
      logic [MAX_WIDTH-1:0] mask;
      shifted = limit >> (idx * width);
      // For width == MAX_WIDTH the shift overflows to 0 and the subtraction
      // wraps to all ones, which is exactly the mask wanted.
      mask    = (MAX_WIDTH'(1) << width) - MAX_WIDTH'(1);
      return shifted[MAX_WIDTH-1:0] & mask;
   endfunction

endpackage

// File: rtl/counter_sched_if.sv
// -----------------------------------------------------------------------------
// counter_sched_if
//
// Bundle of the scheduler's requester-side and status signals.
//
// Handshake: req[i] is a level. A requester raises it and must hold it until
// it sees done[i] (one-cycle pulse while grant[i] is high). Dropping req[i]
// while granted aborts the interval with no done. grant is one-hot or zero.
//
// Signals:
//   req       NREQ        per-requester request level
//   limit     NREQ*WIDTH  per-requester terminal value, slice i = [i*WIDTH +: WIDTH]
//   tick      1           count-enable strobe
//   grant     NREQ        one-hot owner of the counter, or zero
//   done      NREQ        one-cycle completion pulse to the owner
//   busy      1           scheduler not IDLE
//   count     WIDTH       shared counter value
//   state_dbg 2           current FSM state, for observation only
//
// Modports:
//   slave  - the scheduler (consumes req/limit/tick, produces the rest)
//   master - the requester side / environment
// -----------------------------------------------------------------------------
interface counter_sched_if #(
   parameter int NREQ  = counter_sched_pkg::DEF_NREQ,
   parameter int WIDTH = counter_sched_pkg::DEF_WIDTH
);
   import counter_sched_pkg::*;

   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] limit;
   logic                  tick;
   logic [NREQ-1:0]       grant;
   logic [NREQ-1:0]       done;
   logic                  busy;
   logic [WIDTH-1:0]      count;
   state_e                state_dbg;

   modport slave (
      input  req,
      input  limit,
      input  tick,
      output grant,
      output done,
      output busy,
      output count,
      output state_dbg
   );

   modport master (
      output req,
      output limit,
      output tick,
      input  grant,
      input  done,
      input  busy,
      input  count,
      input  state_dbg
   );

endinterface

// File: rtl/counter_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//
// Purely combinational round-robin pick. Searches req starting at index ptr,
// then ptr+1, ... wrapping modulo NREQ, and returns the first set bit as a
// one-hot vector (all zero when nothing is requested). The caller owns ptr.
//
// Ports:
//   req        in   NREQ   request levels
//   ptr        in   IDX_W  index where the search begins (0..NREQ-1)
//   gnt_onehot out  NREQ   one-hot winner, or zero
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NREQ  = 4,
   parameter int IDX_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   output logic [NREQ-1:0]  gnt_onehot
);

   always_comb begin
      logic             found;
      logic [IDX_W-1:0] idx;
      gnt_onehot = '0;
      found      = 1'b0;
      idx        = '0;
      for (int k = 0; k < NREQ; k++) begin
         // Candidate k steps after the pointer, wrapped into 0..NREQ-1.
         idx = IDX_W'((int'(ptr) + k) % NREQ);
         if (!found && req[idx]) begin
            gnt_onehot[idx] = 1'b1;
            found           = 1'b1;
         end
      end
   end

endmodule

// File: rtl/counter_sched.sv
// -----------------------------------------------------------------------------
// counter_sched
//
// Round-robin scheduler sharing one up-counter between NREQ requesters.
// In IDLE the arbiter picks the next requester after the round-robin pointer;
// its limit is latched and the counter runs from 0 on each tick. When a tick
// arrives with count == lim_q the owner gets a one-cycle done (DONE state),
// then the scheduler returns to IDLE and the pointer moves past the owner.
// Dropping req while owning the counter aborts without done. Every output is
// taken straight from a register.
//
// Ports:
//   clk   in   1      rising-edge clock
//   rst   in   1      synchronous active-high reset
//   bus   slave modport of counter_sched_if:
//         req/limit/tick in; grant/done/busy/count/state_dbg out
//
// Parameters:
//   NREQ  2..8 requesters
//   WIDTH counter / limit width (<= MAX_WIDTH)
// -----------------------------------------------------------------------------
module counter_sched
   import counter_sched_pkg::*;
#(
   parameter int NREQ  = DEF_NREQ,
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic           clk,
   input  logic           rst,
   counter_sched_if.slave bus
);

   localparam int IDX_W = $clog2(NREQ);

   // ---------------------------------------------------------------------------
   // Registers and their next values
   // ---------------------------------------------------------------------------
   state_e           state_q, state_n;
   logic [NREQ-1:0]  grant_q, grant_n;
   logic [NREQ-1:0]  done_q,  done_n;
   logic [WIDTH-1:0] count_q, count_n;
   logic [WIDTH-1:0] lim_q,   lim_n;
   logic [IDX_W-1:0] ptr_q,   ptr_n;
   logic [IDX_W-1:0] owner_q, owner_n;

   // ---------------------------------------------------------------------------
   // Combinational helpers
   // ---------------------------------------------------------------------------
   logic [NREQ-1:0]      arb_gnt;
   logic [IDX_W-1:0]     win_idx;
   logic [IDX_W-1:0]     owner_inc;
   logic [LIM_BUS_W-1:0] limit_ext;
   logic                 any_req;
   logic                 owner_req;
   logic                 terminal;

   rr_arbiter #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_arb (
      .req        (bus.req),
      .ptr        (ptr_q),
      .gnt_onehot (arb_gnt)
   );

   // Index of the one-hot arbiter winner.
   always_comb begin
      win_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (arb_gnt[i]) begin
            win_idx = IDX_W'(i);
         end
      end
   end

   assign limit_ext = LIM_BUS_W'(bus.limit);
   assign any_req   = |bus.req;
   assign owner_req = bus.req[owner_q];
   assign terminal  = bus.tick && (count_q == lim_q);

   // Pointer value after serving the current owner, wrapped for any NREQ.
   assign owner_inc = (owner_q == IDX_W'(NREQ - 1)) ? '0 : owner_q + IDX_W'(1);

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_n;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next state and next register values
   // ---------------------------------------------------------------------------
   always_comb begin
      state_n = state_q;
      grant_n = grant_q;
      done_n  = '0;
      count_n = count_q;
      lim_n   = lim_q;
      ptr_n   = ptr_q;
      owner_n = owner_q;

      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               grant_n = arb_gnt;
               owner_n = win_idx;
               lim_n   = WIDTH'(lim_sel(limit_ext, int'(win_idx), WIDTH));
               count_n = '0;
               state_n = ST_RUN;
            end
         end

         ST_RUN: begin
            // Abort is checked first so that it beats a simultaneous
            // terminal tick.
            if (!owner_req) begin
               grant_n = '0;
               count_n = '0;
               ptr_n   = owner_inc;
               state_n = ST_IDLE;
            end else if (terminal) begin
               // count stays at lim_q; it never wraps past the limit.
               done_n  = grant_q;
               state_n = ST_DONE;
            end else if (bus.tick) begin
               count_n = count_q + WIDTH'(1);
            end
         end

         ST_DONE: begin
            grant_n = '0;
            count_n = '0;
            ptr_n   = owner_inc;
            state_n = ST_IDLE;
         end

         default: begin
            grant_n = '0;
            count_n = '0;
            state_n = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         grant_q <= '0;
         done_q  <= '0;
         count_q <= '0;
         lim_q   <= '0;
         ptr_q   <= '0;
         owner_q <= '0;
      end else begin
         grant_q <= grant_n;
         done_q  <= done_n;
         count_q <= count_n;
         lim_q   <= lim_n;
         ptr_q   <= ptr_n;
         owner_q <= owner_n;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign bus.grant     = grant_q;
   assign bus.done      = done_q;
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.count     = count_q;
   assign bus.state_dbg = state_q;

   // ---------------------------------------------------------------------------
   // Structural invariants
   // ---------------------------------------------------------------------------
   a_grant_onehot : assert property (@(posedge clk) disable iff (rst)
      $onehot0(grant_q));

   a_done_to_owner : assert property (@(posedge clk) disable iff (rst)
      ((done_q & ~grant_q) == '0));

   a_count_bounded : assert property (@(posedge clk) disable iff (rst)
      (count_q <= lim_q));

endmodule

// File: tb/tb_counter_sched.sv
// -----------------------------------------------------------------------------
// tb_counter_sched
//
// Bench for counter_sched. A transaction-level reference model (owner index,
// ticks taken, last served requester) predicts the outputs after every clock
// edge; predictions go into exp_q and a negedge monitor compares them with
// the DUT. A few directed order checks sit on top of that.
// -----------------------------------------------------------------------------
module tb_counter_sched;
   import counter_sched_pkg::*;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int W     = 2 * NREQ + 1 + WIDTH;

   // ---------------------------------------------------------------------------
   // Clock / reset / DUT
   // ---------------------------------------------------------------------------
   logic clk;
   logic rst;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   counter_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

   counter_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------------------------------------------------------------------
   // Scoreboard state
   // ---------------------------------------------------------------------------
   logic [W-1:0]    exp_q[$];
   int              n_vec = 0;
   int              n_err = 0;
   logic            rec_on;
   logic [NREQ-1:0] prev_grant;
   logic [NREQ-1:0] gseq[$];

   // ---------------------------------------------------------------------------
   // Reference model: who owns the counter, how many ticks they have had,
   // and who was served last (search starts just after that one).
   // ---------------------------------------------------------------------------
   int m_owner;   // -1 when nobody owns the counter
   int m_phase;   // 0 idle, 1 counting, 2 completion cycle
   int m_taken;   // ticks consumed in this interval
   int m_lim;     // interval is m_lim+1 ticks
   int m_last;    // last served requester

   function automatic logic bit_of(input logic [NREQ-1:0] v, input int i);
      logic [NREQ-1:0] t;
      t = v >> i;
      return t[0];
   endfunction

   function automatic int lim_of(input int j);
      logic [NREQ*WIDTH-1:0] t;
      t = bus.limit >> (j * WIDTH);
      return int'(t[WIDTH-1:0]);
   endfunction

   task automatic model_step();
      if (rst) begin
         m_owner = -1;
         m_phase = 0;
         m_taken = 0;
         m_lim   = 0;
         m_last  = NREQ - 1;
      end else begin
         case (m_phase)
            0: begin
               for (int k = 1; k <= NREQ; k++) begin
                  int j;
                  j = (m_last + k) % NREQ;
                  if (m_owner < 0 && bit_of(bus.req, j)) begin
                     m_owner = j;
                     m_lim   = lim_of(j);
                     m_taken = 0;
                     m_phase = 1;
                  end
               end
            end
            1: begin
               if (!bit_of(bus.req, m_owner)) begin
                  m_last  = m_owner;
                  m_owner = -1;
                  m_taken = 0;
                  m_phase = 0;
               end else if (bus.tick) begin
                  m_taken = m_taken + 1;
                  if (m_taken == m_lim + 1) m_phase = 2;
               end
            end
            default: begin
               m_last  = m_owner;
               m_owner = -1;
               m_taken = 0;
               m_phase = 0;
            end
         endcase
      end
   endtask

   function automatic logic [W-1:0] model_out();
      logic [NREQ-1:0]  g;
      logic [NREQ-1:0]  d;
      logic [WIDTH-1:0] c;
      g = '0;
      if (m_owner >= 0) g = NREQ'(1) << m_owner;
      d = (m_phase == 2) ? g : NREQ'(0);
      c = WIDTH'((m_taken > m_lim) ? m_lim : m_taken);
      return {g, d, (m_phase != 0), c};
   endfunction

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   task automatic cyc();
      @(posedge clk);
      model_step();
      exp_q.push_back(model_out());
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic set_lim(input int j, input int v);
      bus.limit[j*WIDTH +: WIDTH] = WIDTH'(v);
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      bus.req = '0;
      run(2);
      rst     = 1'b0;
   endtask

   task automatic note_timeout(input string what, input logic ok);
      n_vec++;
      if (!ok) begin
         n_err++;
         $display("FAIL %s: condition not reached within cycle budget (got 0, need 1)", what);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Monitor
   // ---------------------------------------------------------------------------
   always @(negedge clk) begin
      logic [W-1:0] e;
      logic [W-1:0] a;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {bus.grant, bus.done, bus.busy, bus.count};
         n_vec++;
         if (a !== e) begin
            n_err++;
            $display("FAIL outputs @%0t: got grant=%b done=%b busy=%b count=%0d, need grant=%b done=%b busy=%b count=%0d",
                     $time, a[W-1 -: NREQ], a[W-1-NREQ -: NREQ], a[WIDTH], a[WIDTH-1:0],
                     e[W-1 -: NREQ], e[W-1-NREQ -: NREQ], e[WIDTH], e[WIDTH-1:0]);
         end
      end
      if (rec_on && prev_grant == '0 && bus.grant != '0) gseq.push_back(bus.grant);
      prev_grant = bus.grant;
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      logic ok;
      logic [NREQ-1:0] exp_g;

      rst        = 1'b1;
      bus.req    = '0;
      bus.limit  = '0;
      bus.tick   = 1'b0;
      rec_on     = 1'b0;
      prev_grant = '0;
      m_owner = -1; m_phase = 0; m_taken = 0; m_lim = 0; m_last = NREQ - 1;

      // Reset state and a single request with limit 3.
      do_reset();
      set_lim(0, 3);
      bus.tick = 1'b1;
      bus.req  = 4'b0001;
      run(7);
      bus.req  = '0;
      run(3);

      // Round-robin fairness with every limit 0.
      do_reset();
      for (int j = 0; j < NREQ; j++) set_lim(j, 0);
      gseq.delete();
      rec_on  = 1'b1;
      bus.req = '1;
      run(22);
      rec_on  = 1'b0;
      bus.req = '0;
      run(3);
      for (int i = 0; i < 5; i++) begin
         exp_g = NREQ'(1) << (i % NREQ);
         n_vec++;
         if (i >= gseq.size()) begin
            n_err++;
            $display("FAIL rr_order[%0d]: got no grant, need %b", i, exp_g);
         end else if (gseq[i] !== exp_g) begin
            n_err++;
            $display("FAIL rr_order[%0d]: got %b, need %b", i, gseq[i], exp_g);
         end
      end

      // Limit 0 and limit 255 boundaries.
      do_reset();
      set_lim(1, 0);
      bus.req = 4'b0010;
      run(4);
      bus.req = '0;
      run(2);
      set_lim(2, 255);
      bus.req = 4'b0100;
      run(262);
      bus.req = '0;
      run(3);

      // Tick on every third cycle only.
      set_lim(3, 5);
      bus.req = 4'b1000;
      for (int c = 0; c < 30; c++) begin
         bus.tick = (c % 3 == 0);
         cyc();
      end
      bus.req  = '0;
      bus.tick = 1'b1;
      run(3);

      // Owner 2 aborts at count 5; requester 3 pending.
      do_reset();
      set_lim(2, 20);
      set_lim(3, 2);
      bus.req = 4'b1100;
      ok = 1'b0;
      for (int b = 0; b < 40; b++) begin
         cyc();
         if (m_owner == 2 && m_taken == 5) begin
            ok = 1'b1;
            break;
         end
      end
      note_timeout("abort_wait", ok);
      bus.req[2] = 1'b0;
      run(10);
      bus.req = '0;
      run(3);

      // Abort in the same cycle as the terminal tick.
      do_reset();
      set_lim(0, 2);
      bus.req = 4'b0001;
      ok = 1'b0;
      for (int b = 0; b < 20; b++) begin
         cyc();
         if (m_owner == 0 && m_phase == 1 && m_taken == m_lim) begin
            ok = 1'b1;
            break;
         end
      end
      note_timeout("terminal_abort_wait", ok);
      bus.req = '0;
      run(4);

      // Reset mid-run at count 7; requester 0 must win afterwards.
      do_reset();
      for (int j = 0; j < NREQ; j++) set_lim(j, 0);
      set_lim(1, 20);
      bus.req = 4'b0010;
      ok = 1'b0;
      for (int b = 0; b < 30; b++) begin
         cyc();
         if (m_owner == 1 && m_taken == 7) begin
            ok = 1'b1;
            break;
         end
      end
      note_timeout("reset_wait", ok);
      rst     = 1'b1;
      bus.req = '1;
      cyc();
      rst     = 1'b0;
      gseq.delete();
      rec_on  = 1'b1;
      run(4);
      rec_on  = 1'b0;
      run(4);
      bus.req = '0;
      run(3);
      n_vec++;
      if (gseq.size() == 0) begin
         n_err++;
         $display("FAIL post_reset_winner: got no grant, need 0001");
      end else if (gseq[0] !== 4'b0001) begin
         n_err++;
         $display("FAIL post_reset_winner: got %b, need 0001", gseq[0]);
      end

      // Limit changed during RUN must not move the terminal count.
      do_reset();
      set_lim(0, 4);
      bus.req = 4'b0001;
      run(2);
      set_lim(0, 1);
      run(8);
      bus.req = '0;
      run(3);

      // Randomized traffic.
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         int b;
         if ($urandom_range(0, 9) == 0) begin
            b = $urandom_range(0, NREQ - 1);
            bus.req[b] = ~bus.req[b];
         end
         if ($urandom_range(0, 19) == 0) set_lim($urandom_range(0, NREQ - 1), $urandom_range(0, 9));
         bus.tick = ($urandom_range(0, 3) != 0);
         rst      = ($urandom_range(0, 299) == 0);
         cyc();
      end
      rst     = 1'b0;
      bus.req = '0;
      run(4);

      @(negedge clk);
      #1;
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d unchecked predictions, need 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
